// File: rtl/mcs_bridge_seq.sv
// Registered MicroBlaze-MCS IO-bus to FPro-bus bridge.
// Decodes the bridge window and selects one of N_SLOT sub-buses. Each
// request becomes a single FPro write or read pulse. Reads wait RD_LAT
// cycles before the data is captured. Every request ends with a
// one-cycle io_ready completion.
module mcs_bridge_seq #(
    parameter logic [31:0] BRG_BASE = 32'h4000_0000,
    parameter int          N_SLOT   = 2,
    parameter int          ADDR_W   = 21,
    parameter int          RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_rd_strobe,
    input  logic              io_wr_strobe,
    input  logic [3:0]        io_byte_enable,
    input  logic [29:0]       io_address,
    input  logic [31:0]       io_write_data,
    output logic [31:0]       io_read_data,
    output logic              io_ready,
    output logic [N_SLOT-1:0] fp_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [3:0]        fp_be,
    output logic [31:0]       fp_wr_data,
    input  logic [31:0]       fp_rd_data,
    input  logic              err_clr,
    output logic [1:0]        err
);

    localparam int SLOT_W = $clog2(N_SLOT);
    localparam int CAP_W  = ADDR_W + SLOT_W;
    // Wait-counter preload; only meaningful when RD_LAT > 0.
    localparam logic [2:0] LAT_M1 = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CAP_W-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic [N_SLOT-1:0] cs_q, cs_d;
    logic              wr_q, rd_q, ready_q;

    logic              hit;
    logic              any_strobe;
    logic [1:0]        err_set;
    logic [SLOT_W-1:0] slot_d;
    logic [N_SLOT-1:0] onehot_d;
    logic [29:0]       unused_addr;

    // The upper address bits are only compared, never stored.
    assign unused_addr = io_address;
    assign hit         = (io_address[29:22] == BRG_BASE[31:24]);
    assign any_strobe  = io_rd_strobe | io_wr_strobe;
    assign slot_d      = addr_d[ADDR_W +: SLOT_W];

    // One-hot select for the slot of the request being (or about to be) served.
    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_cs
            assign onehot_d[gi] = (slot_d == SLOT_W'(gi));
        end
    endgenerate

    // Next-state, request capture, read-data capture and error-set logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_set = 2'b00;
        case (state_q)
            IDLE: begin
                if (any_strobe) begin
                    addr_d  = io_address[CAP_W-1:0];
                    wdata_d = io_write_data;
                    be_d    = io_byte_enable;
                    // A write beats a simultaneous read. The dropped read is an overlap.
                    if (io_rd_strobe && io_wr_strobe) begin
                        err_set[1] = 1'b1;
                    end
                    if (!hit) begin
                        err_set[0] = 1'b1;
                        state_d    = DONE;
                        if (!io_wr_strobe) begin
                            rdata_d = 32'h0000_0000;
                        end
                    end else if (io_wr_strobe) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                state_d = DONE;
            end
            RD: begin
                if (RD_LAT == 0) begin
                    rdata_d = fp_rd_data;
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = fp_rd_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Any strobe outside IDLE, including the io_ready cycle, is an overlap.
        if (state_q != IDLE && any_strobe) begin
            err_set[1] = 1'b1;
        end
        // A set event in the same cycle as err_clr wins.
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
        cs_d  = (state_d == WR || state_d == RD || state_d == RWAIT) ? onehot_d : '0;
    end

    // State, captured request and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            cs_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            wr_q    <= (state_d == WR);
            rd_q    <= (state_d == RD);
            ready_q <= (state_d == DONE);
        end
    end

    assign io_read_data = rdata_q;
    assign io_ready     = ready_q;
    assign fp_cs        = cs_q;
    assign fp_wr        = wr_q;
    assign fp_rd        = rd_q;
    assign fp_addr      = addr_q[ADDR_W-1:0];
    assign fp_be        = be_q;
    assign fp_wr_data   = wdata_q;
    assign err          = err_q;

endmodule
